// File: rtl/prog_seq.sv
// prog_seq: multi-cycle fetch/execute sequencer.
// Each instruction takes two cycles: FETCH loads the instruction register and
// EXEC qualifies the writes. The block owns the program counter, a
// jump-target LUT that is written at run time, the shift-carry register,
// the req/done run handshake and an instruction watchdog.
//
// Ports:
//   i_clk, i_reset           clock; synchronous active-high reset
//   i_req / o_done           run request (level) / run finished (halt or timeout)
//   o_busy                   high in FETCH or EXEC
//   o_timeout                last run was ended by the watchdog
//   o_prog_ctr               instruction ROM address
//   o_fetch_en, o_exec_en    per-stage strobes to decoder/ALU/reg file/dmem
//   i_jump_en, i_jump_cond   conditional branch from the decoder
//   i_lut_idx                jump-LUT index taken from the instruction
//   i_halt                   halt instruction
//   i_sc_o, i_sc_en, i_sc_clr, o_sc   shift-carry capture/clear and value
//   i_lut_wr_en/addr/data    LUT write port (honoured only in IDLE)
module prog_seq #(
  parameter int PC_W       = 12,
  parameter int LUT_AW     = 4,
  parameter int START_ADDR = 0,
  parameter int MAX_INSTR  = 1000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [PC_W-1:0]   o_prog_ctr,
  output logic              o_fetch_en,
  output logic              o_exec_en,
  input  logic              i_jump_en,
  input  logic              i_jump_cond,
  input  logic [LUT_AW-1:0] i_lut_idx,
  input  logic              i_halt,
  input  logic              i_sc_o,
  input  logic              i_sc_en,
  input  logic              i_sc_clr,
  output logic              o_sc,
  input  logic              i_lut_wr_en,
  input  logic [LUT_AW-1:0] i_lut_wr_addr,
  input  logic [PC_W-1:0]   i_lut_wr_data
);

  localparam int CNT_W     = $clog2(MAX_INSTR + 1);
  localparam int LUT_DEPTH = 1 << LUT_AW;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_sc;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;
  logic [PC_W-1:0]  r_lut [LUT_DEPTH];

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [PC_W-1:0]  w_jmp_tgt;
  logic             w_limit;

  assign w_cnt_nxt = r_cnt + CNT_W'(1);
  assign w_limit   = (w_cnt_nxt == CNT_W'(MAX_INSTR));
  assign w_jmp_tgt = r_lut[i_lut_idx];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_pc      <= PC_W'(START_ADDR);
      r_sc      <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      for (int i = 0; i < LUT_DEPTH; i++) r_lut[i] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_lut_wr_en) r_lut[i_lut_wr_addr] <= i_lut_wr_data;
          if (i_req) begin
            r_state   <= FETCH;
            r_pc      <= PC_W'(START_ADDR);
            r_sc      <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
          end
        end
        FETCH: r_state <= EXEC;
        EXEC: begin
          r_cnt <= w_cnt_nxt;
          // The halting instruction still gets its carry update.
          if (i_sc_clr)     r_sc <= 1'b0;
          else if (i_sc_en) r_sc <= i_sc_o;
          // pc is left pointing at the last executed instruction on exit.
          if (i_halt) begin
            r_state <= DONE;
          end else if (w_limit) begin
            r_state   <= DONE;
            r_timeout <= 1'b1;
          end else if (i_jump_en && i_jump_cond) begin
            r_pc    <= w_jmp_tgt;
            r_state <= FETCH;
          end else begin
            r_pc    <= r_pc + PC_W'(1);
            r_state <= FETCH;
          end
        end
        default: begin
          // Requester must drop req before another run can start.
          if (!i_req) r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy     = (r_state == FETCH) || (r_state == EXEC);
  assign o_fetch_en = (r_state == FETCH);
  assign o_exec_en  = (r_state == EXEC);
  assign o_done     = (r_state == DONE);
  assign o_prog_ctr = r_pc;
  assign o_sc       = r_sc;
  assign o_timeout  = r_timeout;

endmodule

// File: doc/prog_seq.md
Name: prog_seq

Overview:
- Parametrised multi-cycle fetch/execute sequencer for the class processor.
- Owns the program counter, a run-time programmable jump-target LUT, the shift-carry (sc) status register, the req/done run handshake and an instruction watchdog.
- Sits between the instruction ROM (drives its address) and the decoder/ALU/reg file/data memory (gives them per-stage enables, takes back branch, halt and carry controls).

Parameters:
- PC_W, 12, program counter width; prog_ctr wraps modulo 2^PC_W.
- LUT_AW, 4, jump-LUT address width; LUT holds 2^LUT_AW entries of PC_W bits.
- START_ADDR, 0, PC value loaded on each run start and on reset.
- MAX_INSTR, 1000, executed-instruction limit before watchdog abort (>=1); counter width clog2(MAX_INSTR+1).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  run request (level).
- done  out  1  run finished (halt or timeout).
- busy  out  1  high in FETCH or EXEC.
- timeout  out  1  last run ended by watchdog.
- prog_ctr  out  PC_W  instruction ROM address.
- fetch_en  out  1  instruction register load strobe.
- exec_en  out  1  write qualifier for reg file, data memory and ALU result.
- jump_en  in  1  decoder: instruction is a conditional branch.
- jump_cond  in  1  branch condition flag.
- lut_idx  in  LUT_AW  jump-LUT index from instruction.
- halt  in  1  decoder: halt instruction.
- sc_o  in  1  carry out of ALU.
- sc_en  in  1  capture sc_o.
- sc_clr  in  1  clear sc.
- sc  out  1  shift-carry register, fed to ALU sc_i.
- lut_wr_en  in  1  LUT write strobe.
- lut_wr_addr  in  LUT_AW  LUT write address.
- lut_wr_data  in  PC_W  LUT write data.

Behaviour:
- States: IDLE, FETCH, EXEC, DONE. Moore outputs:
  - busy = FETCH|EXEC.
  - fetch_en = FETCH.
  - exec_en = EXEC.
  - done = DONE.
- Reset (any state, takes effect next edge):
  - state=IDLE, prog_ctr=START_ADDR, sc=0, timeout=0, instr count=0.
  - All LUT entries=0.
  - done, busy, fetch_en and exec_en are therefore 0.
- IDLE:
  - req=1 → FETCH; prog_ctr<=START_ADDR, sc<=0, count<=0, timeout<=0.
  - Latency is one cycle from the sampled req edge to fetch_en high.
  - Otherwise stay in IDLE.
- FETCH: one cycle → EXEC. prog_ctr and sc hold.
- EXEC: one cycle. Inputs sampled at its closing edge; count<=count+1.
  - Priority 1, halt=1 → DONE; prog_ctr holds (points at the halt instruction).
  - Priority 2, count+1==MAX_INSTR (no halt) → DONE, timeout<=1; prog_ctr holds.
  - Priority 3, jump_en&jump_cond → prog_ctr<=LUT[lut_idx], → FETCH.
  - Else prog_ctr<=prog_ctr+1 (wraps from 2^PC_W-1 to 0), → FETCH.
  - A jump to the current address is legal (tight loop, bounded by the watchdog).
- sc register:
  - Updates only at the closing edge of EXEC, including the halting instruction.
  - sc_clr=1 → 0 (wins over sc_en); else sc_en=1 → sc_o; else hold.
  - sc_en and sc_clr are ignored in all other states.
- DONE:
  - Holds done=1, prog_ctr, sc and timeout.
  - req=0 → IDLE; req=1 → stay (requester must drop req to rearm).
- Run timing: each instruction takes exactly 2 cycles. A program of N instructions ending in halt gives done high 2N+1 cycles after the req-sampled edge.
- LUT:
  - Write is synchronous and honoured only in IDLE; writes in other states are ignored.
  - Read is combinational by lut_idx.
  - Contents persist across runs and are cleared only by reset.
- req is ignored in FETCH/EXEC; a run cannot be aborted except by reset.
- Reset mid-run: next edge IDLE with all reset values; no further fetch_en/exec_en pulses.

Test Plan:
- Reset, then req=1 with halt low for 3 instructions and high on the 4th → fetch_en/exec_en alternate; prog_ctr 0,1,2,3; done=1 nine cycles after the req edge; prog_ctr=3, timeout=0.
- In IDLE write LUT[5]=0x040, run, assert jump_en=1, jump_cond=1, lut_idx=5 on the first EXEC → prog_ctr=0x040 at the next FETCH. Repeat with jump_cond=0 → prog_ctr=1.
- In EXEC drive sc_en=1, sc_o=1 → sc=1. Next EXEC drive sc_en=1, sc_clr=1 → sc=0. Drive sc_en=1 during FETCH → sc unchanged. New run start → sc=0.
- MAX_INSTR=4 with halt never asserted → done=1 and timeout=1 after the 4th EXEC; prog_ctr=3. Drop req → IDLE. Re-req → timeout clears.
- Set LUT[0]=0xFFF with PC_W=12, jump there, then step without jumping → prog_ctr wraps 0xFFF→0x000. Write LUT during busy → entry unchanged.
- Assert reset during the second EXEC → next cycle IDLE, prog_ctr=START_ADDR, sc=0, all outputs 0, LUT entries 0. Hold req=1 through DONE → done stays high until req=0.
